// File: rtl/button_events.sv
// Turns a debounced switch level into press / release / hold-to-repeat pulses.
// Define BUTTON_EVENTS_REPEAT_EN to build the auto-repeat counter; otherwise o_Repeat is tied low.
module button_events #(
   parameter int unsigned c_HOLD_DELAY    = 12500000,
   parameter int unsigned c_REPEAT_PERIOD = 2500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_Switch,
   output logic o_Press,
   output logic o_Release,
   output logic o_Repeat,
   output logic o_Held
);

   // Elaboration-time range guards; an out-of-range value leaves an empty marker block.
   if (c_HOLD_DELAY < 2 || c_HOLD_DELAY > 32'h00FF_FFFF) begin : g_bad_hold_delay
   end
   if (c_REPEAT_PERIOD < 2 || c_REPEAT_PERIOD > 32'h00FF_FFFF) begin : g_bad_repeat_period
   end

`ifdef BUTTON_EVENTS_REPEAT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
`else
   typedef enum logic {ST_IDLE, ST_HELD} state_t;
`endif

   state_t state_q, state_d;
   logic   prev_q;
   logic   press_q, press_d;
   logic   release_q, release_d;
   logic   held_q, held_d;
   logic   rise, fall;

   assign rise = i_Switch & ~prev_q;
   assign fall = ~i_Switch & prev_q;

`ifdef BUTTON_EVENTS_REPEAT_EN
   localparam logic [23:0] HOLD_LAST   = 24'(c_HOLD_DELAY - 1);
   localparam logic [23:0] REPEAT_LAST = 24'(c_REPEAT_PERIOD - 1);

   logic [23:0] count_q, count_d;
   logic        repeat_q, repeat_d;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               press_d = 1'b1;
               count_d = '0;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            // A release takes priority over a repeat falling due in the same cycle.
            if (fall) begin
               release_d = 1'b1;
               count_d   = '0;
               state_d   = ST_IDLE;
            end else if (count_q == HOLD_LAST) begin
               repeat_d = 1'b1;
               count_d  = '0;
               state_d  = ST_REPEAT;
            end else begin
               count_d = count_q + 24'd1;
            end
         end
         ST_REPEAT: begin
            if (fall) begin
               release_d = 1'b1;
               count_d   = '0;
               state_d   = ST_IDLE;
            end else if (count_q == REPEAT_LAST) begin
               repeat_d = 1'b1;
               count_d  = '0;
            end else begin
               count_d = count_q + 24'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
      held_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         count_q  <= '0;
         repeat_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         repeat_q <= repeat_d;
      end
   end

   assign o_Repeat = repeat_q;
`else
   always_comb begin
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               press_d = 1'b1;
               state_d = ST_HELD;
            end
         end
         ST_HELD: begin
            if (fall) begin
               release_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      held_d = (state_d != ST_IDLE);
   end

   assign o_Repeat = 1'b0;
`endif

   // prev_q tracks the switch even during reset so a level held across reset is not a press.
   always_ff @(posedge i_clk) begin
      prev_q <= i_Switch;
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         held_q    <= held_d;
      end
   end

   assign o_Press   = press_q;
   assign o_Release = release_q;
   assign o_Held    = held_q;

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events (c_HOLD_DELAY=8, c_REPEAT_PERIOD=4); repeat
// expectations are included only when BUTTON_EVENTS_REPEAT_EN is defined.
module tb_button_events;

   localparam int K_PRESS   = 0;
   localparam int K_RELEASE = 1;
   localparam int K_REPEAT  = 2;
   localparam int K_HON     = 3;
   localparam int K_HOFF    = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic sw;
   logic o_press, o_release, o_repeat, o_held;

   int   cyc = 0;
   int   base = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_q[$];
   bit   mon_en = 1'b0;
   logic held_prev = 1'b0;

   button_events #(
      .c_HOLD_DELAY   (8),
      .c_REPEAT_PERIOD(4)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_Switch (sw),
      .o_Press  (o_press),
      .o_Release(o_release),
      .o_Repeat (o_repeat),
      .o_Held   (o_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_PRESS:   return "press";
         K_RELEASE: return "release";
         K_REPEAT:  return "repeat";
         K_HON:     return "held_rise";
         default:   return "held_fall";
      endcase
   endfunction

   // Expected event at scenario-relative cycle c.
   task automatic expect_ev(input int k, input int c);
      exp_q.push_back((base + c) * 8 + k);
   endtask

   task automatic observe(input int k);
      int e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL event: got %s at cycle %0d, required no event", kname(k), cyc - base);
      end else begin
         e = exp_q.pop_front();
         if (e != cyc * 8 + k) begin
            n_bad++;
            $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                     kname(k), cyc - base, kname(e % 8), e / 8 - base);
         end else begin
            $display("ok   event %s at cycle %0d", kname(k), cyc - base);
         end
      end
   endtask

   task automatic check_val(input string name, input logic act, input logic req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc - base);
      end else begin
         $display("ok   %s = %b (cycle %0d)", name, act, cyc - base);
      end
   endtask

   task automatic run_to(input int n);
      while (cyc < base + n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic new_scenario(input string name);
      base = cyc;
      $display("---- %s (edge 0 = cycle %0d)", name, base);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (o_press)             observe(K_PRESS);
         if (o_release)           observe(K_RELEASE);
         if (o_repeat)            observe(K_REPEAT);
         if (o_held && !held_prev) observe(K_HON);
         if (!o_held && held_prev) observe(K_HOFF);
         held_prev = o_held;
      end
   end

   initial begin
      rst_n = 1'b0;
      sw    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_val("reset_press",   o_press,   1'b0);
      check_val("reset_release", o_release, 1'b0);
      check_val("reset_repeat",  o_repeat,  1'b0);
      check_val("reset_held",    o_held,    1'b0);
      held_prev = 1'b0;
      mon_en    = 1'b1;
      @(posedge clk);
      #1;

      // Short press: rise at 10, fall at 13.
      new_scenario("short press");
      expect_ev(K_PRESS, 11);
      expect_ev(K_HON, 11);
      expect_ev(K_RELEASE, 14);
      expect_ev(K_HOFF, 14);
      run_to(10); sw = 1'b1;
      run_to(13); sw = 1'b0;
      run_to(20);

      // Long hold: rise at 10, fall at 40.
      new_scenario("long hold");
      expect_ev(K_PRESS, 11);
      expect_ev(K_HON, 11);
`ifdef BUTTON_EVENTS_REPEAT_EN
      for (int i = 0; i < 6; i++) expect_ev(K_REPEAT, 19 + 4 * i);
`endif
      expect_ev(K_RELEASE, 41);
      expect_ev(K_HOFF, 41);
      run_to(10); sw = 1'b1;
      run_to(40); sw = 1'b0;
      run_to(50);

      // Release in the cycle the first repeat is due.
      new_scenario("release vs first repeat");
      expect_ev(K_PRESS, 11);
      expect_ev(K_HON, 11);
      expect_ev(K_RELEASE, 19);
      expect_ev(K_HOFF, 19);
      run_to(10); sw = 1'b1;
      run_to(18); sw = 1'b0;
      run_to(28);

      // Switch held through reset, then re-pressed.
      new_scenario("held through reset");
      rst_n = 1'b0;
      sw    = 1'b1;
      expect_ev(K_PRESS, 26);
      expect_ev(K_HON, 26);
      expect_ev(K_RELEASE, 31);
      expect_ev(K_HOFF, 31);
      run_to(5); rst_n = 1'b1;
      run_to(15);
      @(negedge clk);
      check_val("held_after_reset",  o_held,  1'b0);
      check_val("press_after_reset", o_press, 1'b0);
      run_to(20); sw = 1'b0;
      run_to(25); sw = 1'b1;
      run_to(30); sw = 1'b0;
      run_to(40);

      // Reset mid-hold: rise at 10, reset at 21 through 24, release at 30.
      new_scenario("reset mid-hold");
      expect_ev(K_PRESS, 11);
      expect_ev(K_HON, 11);
`ifdef BUTTON_EVENTS_REPEAT_EN
      expect_ev(K_REPEAT, 19);
`endif
      expect_ev(K_HOFF, 22);
      run_to(10); sw = 1'b1;
      run_to(21); rst_n = 1'b0;
      run_to(22);
      @(negedge clk);
      check_val("midreset_press",   o_press,   1'b0);
      check_val("midreset_release", o_release, 1'b0);
      check_val("midreset_repeat",  o_repeat,  1'b0);
      check_val("midreset_held",    o_held,    1'b0);
      run_to(24); rst_n = 1'b1;
      run_to(30); sw = 1'b0;
      run_to(45);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected events never seen, required 0 (first %s at cycle %0d)",
                  exp_q.size(), kname(exp_q[0] % 8), exp_q[0] / 8);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
